xc_malu_mul_seq: RTL and testbench

Iterative shift-add multiplier for the multi-cycle ALU, the inverse operation of the restoring divider. It executes `mul`, `mulh`, `mulhsu` and `mulhu`, one multiplier bit per cycle, from its own internal state registers. It sits beside the divider behind the same valid/ready request style used by the MALU dispatch logic.

---
 rtl/xc_malu_mul_seq.sv | 123 ++++++++++++
 tb/tb_xc_malu_mul_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/xc_malu_mul_seq.sv
// Iterative shift-add multiplier for the multi-cycle ALU: mul, mulh, mulhsu, mulhu,
// one multiplier bit per cycle over 32 RUN cycles, then a single DONE cycle.
module xc_malu_mul_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        busy,
    output logic        ready,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        neg_q, neg_d;
    logic [31:0] m1_q, m1_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;

    logic        s1_s, s2_s;
    logic [31:0] m2_s;
    logic [32:0] sum_s;
    logic [63:0] prod_s;

    // Next-state logic: operand capture at start, one shift-add step per RUN cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        m1_d    = m1_q;
        acc_d   = acc_q;
        count_d = count_q;
        s1_s    = rs1[31] & ((op == OP_MULH) | (op == OP_MULHSU));
        s2_s    = rs2[31] & (op == OP_MULH);
        m2_s    = s2_s ? (~rs2 + 32'd1) : rs2;
        sum_s   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m1_q} : 33'd0);
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    op_d    = op;
                    neg_d   = s1_s ^ s2_s;
                    m1_d    = s1_s ? (~rs1 + 32'd1) : rs1;
                    acc_d   = {32'd0, m2_s};
                    count_d = 5'd0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = {sum_s, acc_q[31:1]};
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Flush wins over everything, including a start in the same cycle.
        if (flush) begin
            state_d = ST_IDLE;
            count_d = 5'd0;
        end else begin
            state_d = state_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 2'b00;
            neg_q   <= 1'b0;
            m1_q    <= 32'd0;
            acc_q   <= 64'd0;
            count_q <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            m1_q    <= m1_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    // Outputs decoded purely from registered state; negation is the only logic on the result path.
    always_comb begin
        prod_s = neg_q ? (~acc_q + 64'd1) : acc_q;
        busy   = (state_q == ST_RUN) | (state_q == ST_DONE);
        ready  = (state_q == ST_DONE);
        if (state_q == ST_DONE) begin
            if (op_q == OP_MUL) begin
                result = prod_s[31:0];
            end else begin
                result = prod_s[63:32];
            end
        end else begin
            result = 32'd0;
        end
    end

endmodule

// File: tb/tb_xc_malu_mul_seq.sv
// Directed self-checking bench for xc_malu_mul_seq with hand-computed products.
module tb_xc_malu_mul_seq;

    logic        clock;
    logic        reset;
    logic        valid;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        ready;
    logic [31:0] result;

    int pass_cnt;
    int total_cnt;

    xc_malu_mul_seq dut (
        .clock  (clock),
        .reset  (reset),
        .valid  (valid),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .ready  (ready),
        .result (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Starts an op (edge 0 is the next rising edge), holds valid until ready and
    // reports the cycle ready appeared in (-1 on timeout).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output logic [31:0] res, output int lat,
                          output int busy_err);
        @(negedge clock);
        valid = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        @(posedge clock);
        lat      = -1;
        res      = 32'hDEADBEEF;
        busy_err = 0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clock);
            if (busy !== 1'b1) busy_err++;
            if (ready === 1'b1) begin
                lat   = c;
                res   = result;
                valid = 1'b0;
            end else begin
                if (result !== 32'd0) busy_err++;
                if (scramble) begin
                    rs1 = $urandom;
                    rs2 = $urandom;
                    op  = 2'($urandom_range(0, 3));
                end
            end
        end
        valid = 1'b0;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total_cnt++;
        if ({busy, ready, result} !== 34'd0)
            $display("FAIL reset_outputs: busy=%b ready=%b result=0x%08h expected 0/0/0", busy, ready, result);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mul_basic();
        logic [31:0] r;
        int lat, be;
        run_op(2'b00, 32'd3, 32'd5, 1'b0, r, lat, be);
        total_cnt++;
        if (lat !== 33) $display("FAIL mul_latency: got %0d expected 33", lat);
        else pass_cnt++;
        chk32("mul_3x5", r, 32'd15);
        total_cnt++;
        if (be !== 0) $display("FAIL mul_busy_window: %0d bad cycles expected 0", be);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (busy !== 1'b0 || ready !== 1'b0)
            $display("FAIL mul_after_done: busy=%b ready=%b expected 0/0", busy, ready);
        else pass_cnt++;
    endtask

    task automatic test_signed_ops();
        logic [31:0] r;
        int lat, be;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, lat, be);
        chk32("mulh_m1_m1", r, 32'h00000000);
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, lat, be);
        chk32("mul_m1_m1", r, 32'h00000001);
        run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, lat, be);
        chk32("mulhu_max", r, 32'hFFFFFFFE);
        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, lat, be);
        chk32("mulhsu_m1_max", r, 32'hFFFFFFFF);
        run_op(2'b01, 32'h80000000, 32'h80000000, 1'b0, r, lat, be);
        chk32("mulh_min_min", r, 32'h40000000);
        run_op(2'b01, 32'hFFFFFFFD, 32'd7, 1'b0, r, lat, be);
        chk32("mulh_m3_7", r, 32'hFFFFFFFF);
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, r, lat, be);
        chk32("mul_m3_7", r, 32'hFFFFFFEB);
        run_op(2'b11, 32'h12345678, 32'h00010000, 1'b0, r, lat, be);
        chk32("mulhu_shift16", r, 32'h00001234);
    endtask

    task automatic test_operand_change();
        logic [31:0] r;
        int lat, be;
        run_op(2'b00, 32'd7, 32'd9, 1'b1, r, lat, be);
        chk32("mul_7x9_scrambled", r, 32'd63);
    endtask

    task automatic test_back_to_back();
        int first, second;
        logic [31:0] r1, r2;
        first = -1; second = -1; r1 = 32'd0; r2 = 32'd0;
        @(negedge clock);
        valid = 1'b1; op = 2'b00; rs1 = 32'd6; rs2 = 32'd7;
        @(posedge clock);
        for (int c = 1; c <= 80 && second < 0; c++) begin
            @(negedge clock);
            if (ready === 1'b1) begin
                if (first < 0) begin
                    first = c; r1 = result;
                end else begin
                    second = c; r2 = result; valid = 1'b0;
                end
            end
        end
        valid = 1'b0;
        total_cnt++;
        if (first !== 33 || second !== 67)
            $display("FAIL b2b_timing: ready cycles %0d,%0d expected 33,67", first, second);
        else pass_cnt++;
        chk32("b2b_first", r1, 32'd42);
        chk32("b2b_second", r2, 32'd42);
    endtask

    // Aborts a run either with flush or with reset at the given RUN cycle.
    task automatic abort_run(input bit use_reset, input int at_cycle, input string name);
        int readies;
        readies = 0;
        @(negedge clock);
        valid = 1'b1; op = 2'b00; rs1 = 32'd5; rs2 = 32'd5;
        @(posedge clock);
        #1 valid = 1'b0;
        for (int c = 1; c < at_cycle; c++) begin
            @(negedge clock);
            if (ready === 1'b1) readies++;
        end
        @(negedge clock);
        if (use_reset) reset = 1'b1;
        else flush = 1'b1;
        @(negedge clock);
        reset = 1'b0; flush = 1'b0;
        total_cnt++;
        if ({busy, ready, result} !== 34'd0)
            $display("FAIL %s_next_cycle: busy=%b ready=%b result=0x%08h expected 0/0/0", name, busy, ready, result);
        else pass_cnt++;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (ready === 1'b1 || busy === 1'b1) readies++;
        end
        total_cnt++;
        if (readies !== 0) $display("FAIL %s_no_ready: %0d active cycles expected 0", name, readies);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int lat, be;
        abort_run(1'b0, 10, "flush");
        run_op(2'b00, 32'd2, 32'd2, 1'b0, r, lat, be);
        total_cnt++;
        if (lat !== 33 || r !== 32'd4)
            $display("FAIL flush_recover: lat=%0d result=0x%08h expected 33/0x00000004", lat, r);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int lat, be;
        abort_run(1'b1, 15, "reset_mid");
        run_op(2'b00, 32'd2, 32'd2, 1'b0, r, lat, be);
        total_cnt++;
        if (lat !== 33 || r !== 32'd4)
            $display("FAIL reset_recover: lat=%0d result=0x%08h expected 33/0x00000004", lat, r);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        reset = 1'b1; valid = 1'b0; op = 2'b00; rs1 = 32'd0; rs2 = 32'd0; flush = 1'b0;
        test_reset();
        test_mul_basic();
        test_signed_ops();
        test_operand_change();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
